spi_slave_tx: RTL and testbench
===============================

// Module: spi_slave_tx
// PURPOSE
//  SPI slave transmit path: drives o_MISO back to an SPI master, mirroring the receive-only SPI_Slave.
//  User logic pushes bytes into a small FIFO in the clk domain.
//  The block shifts each byte out on i_SPCK while i_CS_n is low, then pops the next byte.
//  Sits beside SPI_Slave on the same i_SPCK/i_CS_n pins and shares its SPI_MODE.
// PARAMETERS
//  SPI_MODE    3      CPOL=SPI_MODE[1], CPHA=SPI_MODE[0]; legal values 0..3
//  FIFO_DEPTH  4      TX FIFO entries; power of 2, >=2
//  IDLE_BYTE   8'hFF  byte shifted out when the FIFO is empty at a byte boundary
// PORTS
//  clk           in   1                        system clock
//  rst_n         in   1                        asynchronous, active-low reset
//  i_TX_Byte     in   8                        byte to queue
//  i_TX_En       in   1                        push strobe; accepted only when o_TX_Ready=1
//  o_TX_Ready    out  1                        FIFO not full
//  o_FIFO_Count  out  $clog2(FIFO_DEPTH+1)     bytes queued (not counting the shifter)
//  o_TX_Done     out  1                        1-clk pulse when the 8th bit of a byte has been shifted
//  o_Underrun    out  1                        1-clk pulse when IDLE_BYTE is loaded because the FIFO is empty
//  i_SPCK        in   1                        SPI clock from master (async)
//  i_CS_n        in   1                        chip select, active low (async)
//  o_MISO        out  1                        serial data to master
//  o_MISO_OE     out  1                        MISO output enable; 1 only while CS is active
// BEHAVIOUR
//  - Reset values: o_TX_Ready=1, o_FIFO_Count=0, o_TX_Done=0, o_Underrun=0, o_MISO=0, o_MISO_OE=0.
//  - Reset clears the FIFO, the shifter and the bit counter.
//  - Input sync: i_SPCK and i_CS_n pass through 2-flop synchronisers; edges are detected on the synced copies.
//  - Timing requirement: master SPCK half-period >=4 clk; CS_n-fall to first SPCK edge >=4 clk.
//  - Edge roles:
//    - Leading edge = rising if CPOL=0, else falling.
//    - CPHA=0: MISO changes on trailing edges.
//    - CPHA=1: MISO changes on leading edges.
//  - FSM IDLE -> LOAD -> SHIFT:
//    - IDLE: CS high; OE=0, MISO=0. Synced CS fall -> LOAD.
//    - LOAD (1 clk): pop FIFO into shifter, or load IDLE_BYTE and pulse o_Underrun; bitcnt=0; OE=1; -> SHIFT.
//    - CPHA=0: MISO = bit 7 at the end of LOAD (3 clk after raw CS fall).
//    - CPHA=1: MISO holds bit 7 from LOAD; the first leading edge re-presents bit 7 and no shift occurs.
//    - SHIFT: each change-edge presents the next bit, MSB first, and increments bitcnt (3 bits, wraps 7->0).
//    - Byte end: at the sample edge of bit 7, pulse o_TX_Done.
//    - Next byte: the next change-edge loads the next byte (pop or IDLE_BYTE/underrun) and presents its bit 7.
//    - Multi-byte transfers therefore stream back-to-back without gaps.
//    - Any state: synced CS rise -> IDLE.
//  - CS rise mid-byte: partially sent byte is discarded (not re-queued); no o_TX_Done; OE=0 on the next clk.
//  - FIFO push/pop rules:
//    - Push when full is ignored (no overwrite).
//    - Simultaneous push and pop: both occur, and the count is unchanged.
//    - o_TX_Ready and o_FIFO_Count are registered and reflect the post-update count.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - Reset asserted mid-transfer: outputs go to their reset values immediately (async).
// CONFIGURATION
//  - Macro SPI_SLAVE_TX_LSB_FIRST_EN:
//    - Defined: bits are shifted LSB first, and the first presented bit is bit 0.
//    - Undefined (default): MSB first, as above.
//  - All other behaviour is identical in both builds.
// TESTING
//  - Reset, push A5,3C,0F; master mode 3, CLKS_PER_HALF_BIT=5, 3-byte CS.
//    -> master RX A5,3C,0F; 3 o_TX_Done pulses; no underrun.
//  - Repeat the first scenario in modes 0, 1 and 2 -> identical bytes received.
//    -> In modes 0/2, MISO = bit 7 before the first SPCK edge.
//  - Push 81 only; 3-byte CS -> master RX 81,FF,FF; o_Underrun pulses twice; FIFO_Count goes 1->0.
//  - Push 5 bytes with DEPTH=4 and no CS -> o_TX_Ready=0 after the 4th push.
//    -> 5th byte is dropped; a later 4-byte transfer returns the first 4 bytes.
//  - CS raised after 4 bits of C3, then a new CS -> next byte comes from the FIFO (C3 not resent).
//    -> No o_TX_Done for C3; OE is low while CS is high.
//  - rst_n pulled low mid-byte -> o_MISO_OE=0 and o_FIFO_Count=0 asynchronously.
//    -> After release, o_TX_Ready=1.

Source files
------------

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI slave transmit path with a small TX FIFO, sharing SPCK/CS_n with the receiver.
// Build option: define SPI_SLAVE_TX_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_slave_tx #(
    parameter int SPI_MODE = 3,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        i_TX_Byte,
    input  logic                              i_TX_En,
    output logic                              o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_FIFO_Count,
    output logic                              o_TX_Done,
    output logic                              o_Underrun,
    input  logic                              i_SPCK,
    input  logic                              i_CS_n,
    output logic                              o_MISO,
    output logic                              o_MISO_OE
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam bit CPOL = SPI_MODE[1];
    localparam bit CPHA = SPI_MODE[0];

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_nxt;
    logic [2:0] spck_sync;
    logic [1:0] cs_sync;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nxt;
    logic [7:0] shreg, shifted;
    logic [2:0] bitcnt;
    logic ready, done, underrun, first, bit_out;
    logic cs_n, rise, fall, lead, trail, chg, smp;
    logic load, shift, push, pop, empty, full;

    // spck_sync[1] is the synchronised level, spck_sync[2] its previous value
    assign cs_n  = cs_sync[1];
    assign rise  = spck_sync[1] & ~spck_sync[2];
    assign fall  = ~spck_sync[1] & spck_sync[2];
    assign lead  = CPOL ? fall : rise;
    assign trail = CPOL ? rise : fall;
    assign chg   = CPHA ? lead : trail;
    assign smp   = CPHA ? trail : lead;

`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
    assign bit_out = shreg[0];
    assign shifted = {1'b0, shreg[7:1]};
`else
    assign bit_out = shreg[7];
    assign shifted = {shreg[6:0], 1'b0};
`endif

    assign empty = count == '0;
    assign full  = count == CW'(FIFO_DEPTH);
    assign push  = i_TX_En & ~full;
    assign pop   = load & ~empty;
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_comb begin
        state_nxt = cs_n ? IDLE : (state == IDLE) ? LOAD : SHIFT;
        // with CPHA=1 the first change edge only re-presents the loaded bit
        load  = ~cs_n & ((state == LOAD) | ((state == SHIFT) & chg & ~first & (bitcnt == 3'd7)));
        shift = ~cs_n & (state == SHIFT) & chg & ~first & (bitcnt != 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spck_sync <= {3{CPOL}};
            cs_sync   <= 2'b11;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ready     <= 1'b1;
            shreg     <= '0;
            bitcnt    <= '0;
            first     <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            spck_sync <= {spck_sync[1:0], i_SPCK};
            cs_sync   <= {cs_sync[0], i_CS_n};
            wptr      <= wptr + AW'(push);
            rptr      <= rptr + AW'(pop);
            count     <= count_nxt;
            ready     <= count_nxt != CW'(FIFO_DEPTH);
            shreg     <= load ? (empty ? IDLE_BYTE : mem[rptr]) : shift ? shifted : shreg;
            bitcnt    <= load ? 3'd0 : shift ? bitcnt + 3'd1 : bitcnt;
            first     <= (state == LOAD) ? CPHA : first & ~((state == SHIFT) & chg);
            done      <= ~cs_n & (state == SHIFT) & smp & (bitcnt == 3'd7);
            underrun  <= load & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= i_TX_Byte;
    end

    assign o_TX_Ready   = ready;
    assign o_FIFO_Count = count;
    assign o_TX_Done    = done;
    assign o_Underrun   = underrun;
    assign o_MISO       = (state == SHIFT) & bit_out;
    assign o_MISO_OE    = state != IDLE;
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: one DUT per SPI mode driven by a behavioural SPI master and a queue-based FIFO model.
module tb_spi_slave_tx;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] tx_byte;
    logic tx_en [4];
    logic tx_ready [4];
    logic [2:0] fifo_count [4];
    logic tx_done [4];
    logic underrun [4];
    logic spck [4];
    logic cs_n [4];
    logic miso [4];
    logic miso_oe [4];
    logic [7:0] mq [4][$];
    int done_cnt [4];
    int und_cnt [4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_tx #(.SPI_MODE(g)) dut (
            .clk(clk), .rst_n(rst_n), .i_TX_Byte(tx_byte), .i_TX_En(tx_en[g]),
            .o_TX_Ready(tx_ready[g]), .o_FIFO_Count(fifo_count[g]), .o_TX_Done(tx_done[g]),
            .o_Underrun(underrun[g]), .i_SPCK(spck[g]), .i_CS_n(cs_n[g]),
            .o_MISO(miso[g]), .o_MISO_OE(miso_oe[g])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (tx_done[k] === 1'b1) done_cnt[k]++;
            if (underrun[k] === 1'b1) und_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] shin(input logic [7:0] r, input logic b);
`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
        return {b, r[7:1]};
`else
        return {r[6:0], b};
`endif
    endfunction

    function automatic logic first_bit(input logic [7:0] x);
`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
        return x[0];
`else
        return x[7];
`endif
    endfunction

    task automatic push(input int m, input logic [7:0] b);
        check($sformatf("ready m%0d", m), tx_ready[m], mq[m].size() < 4);
        tx_byte = b;
        tx_en[m] = 1'b1;
        @(negedge clk);
        tx_en[m] = 1'b0;
        if (mq[m].size() < 4) mq[m].push_back(b);
        @(negedge clk);
        check($sformatf("count m%0d", m), fifo_count[m], mq[m].size());
    endtask

    // Master transfer of nbits; every byte-boundary change edge (and the CS fall) loads a byte.
    task automatic xfer(input int m, input int nbits);
        bit cpol, cpha;
        int nloads, eu, d0, u0;
        logic [7:0] loaded [$];
        logic [7:0] rx, b;
        cpol = m[1];
        cpha = m[0];
        nloads = cpha ? 1 + (nbits - 1) / 8 : 1 + nbits / 8;
        eu = 0;
        for (int i = 0; i < nloads; i++) begin
            if (mq[m].size() > 0) b = mq[m].pop_front();
            else begin
                b = 8'hFF;
                eu++;
            end
            loaded.push_back(b);
        end
        d0 = done_cnt[m];
        u0 = und_cnt[m];
        cs_n[m] = 1'b0;
        repeat (8) @(negedge clk);
        check($sformatf("oe_on m%0d", m), miso_oe[m], 1);
        b = loaded[0];
        if (!cpha) check($sformatf("pre m%0d", m), miso[m], first_bit(b));
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spck[m] = ~cpol;
            if (!cpha) rx = shin(rx, miso[m]);
            repeat (5) @(negedge clk);
            spck[m] = cpol;
            if (cpha) rx = shin(rx, miso[m]);
            repeat (5) @(negedge clk);
            if (i % 8 == 7) check($sformatf("rx m%0d b%0d", m, i / 8), rx, loaded[i / 8]);
        end
        cs_n[m] = 1'b1;
        repeat (6) @(negedge clk);
        check($sformatf("oe_off m%0d", m), miso_oe[m], 0);
        check($sformatf("done m%0d", m), done_cnt[m] - d0, nbits / 8);
        check($sformatf("underrun m%0d", m), und_cnt[m] - u0, eu);
        check($sformatf("count_end m%0d", m), fifo_count[m], mq[m].size());
    endtask

    initial begin
        int m, n, nbits;
        rst_n = 1'b0;
        tx_byte = '0;
        for (int k = 0; k < 4; k++) begin
            tx_en[k] = 1'b0;
            cs_n[k] = 1'b1;
            spck[k] = k[1];
            done_cnt[k] = 0;
            und_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst ready", tx_ready[k], 1);
            check("rst count", fifo_count[k], 0);
            check("rst done", tx_done[k], 0);
            check("rst underrun", underrun[k], 0);
            check("rst miso", miso[k], 0);
            check("rst oe", miso_oe[k], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 3; k < 7; k++) begin
            m = k % 4;
            push(m, 8'hA5);
            push(m, 8'h3C);
            push(m, 8'h0F);
            xfer(m, 24);
        end

        push(3, 8'h81);
        xfer(3, 24);

        for (int i = 0; i < 5; i++) push(3, 8'h10 + 8'(i));
        check("full ready", tx_ready[3], 0);
        xfer(3, 32);

        push(3, 8'hC3);
        push(3, 8'h11);
        xfer(3, 4);
        xfer(3, 8);

        for (int it = 0; it < 24; it++) begin
            m = $urandom_range(0, 3);
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) push(m, 8'($urandom));
            nbits = $urandom_range(0, 1) ? 8 * $urandom_range(1, 3) : $urandom_range(1, 20);
            xfer(m, nbits);
        end

        push(3, 8'h12);
        push(3, 8'h34);
        push(3, 8'h56);
        cs_n[3] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            spck[3] = 1'b0;
            repeat (5) @(negedge clk);
            spck[3] = 1'b1;
            repeat (5) @(negedge clk);
        end
        spck[3] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async oe", miso_oe[3], 0);
        check("async count", fifo_count[3], 0);
        check("async miso", miso[3], 0);
        cs_n[3] = 1'b1;
        spck[3] = 1'b1;
        for (int k = 0; k < 4; k++) mq[k].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst ready", tx_ready[3], 1);
        check("post rst count", fifo_count[3], 0);
        push(3, 8'h77);
        xfer(3, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
